// File: rtl/signal_analyzer.sv
// signal_analyzer
//   Measures the period and the min/max amplitude of an 8-bit waveform.
//   A hysteretic region tracker (UNKNOWN/LOW/HIGH) detects rising
//   crossings of MID. A two-state measurement FSM (IDLE/RUN) counts the
//   valid samples between consecutive rising crossings. It reports
//   period/min/max with a one-cycle result_valid pulse, and it abandons
//   a window that grows too long.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active low
//   sample_valid : sample is accepted this cycle
//   sample[7:0]  : unsigned waveform code
//   clear        : synchronous restart of the measurement
//   result_valid : one-cycle pulse when period/min_val/max_val update
//   period[15:0] : valid samples in the last complete cycle
//   min_val[7:0] : minimum sample in the last complete cycle
//   max_val[7:0] : maximum sample in the last complete cycle
//   lock         : last two reported periods are equal
//   timeout      : one-cycle pulse when a window is abandoned
module signal_analyzer #(
    parameter int          MID     = 127,
    parameter int          HYST    = 8,
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [7:0]  sample,
    input  logic        clear,
    output logic        result_valid,
    output logic [15:0] period,
    output logic [7:0]  min_val,
    output logic [7:0]  max_val,
    output logic        lock,
    output logic        timeout
);

    localparam logic [7:0] LO_TH = 8'(MID - HYST);
    localparam logic [7:0] HI_TH = 8'(MID + HYST);

    typedef enum logic [1:0] {R_UNKNOWN, R_LOW, R_HIGH} region_t;
    typedef enum logic {S_IDLE, S_RUN} state_t;

    region_t     region, region_nxt;
    state_t      state;
    logic [15:0] cnt, cnt_inc;
    logic [7:0]  wmin, wmax, win_min, win_max;
    logic        crossing, tmo_hit, have_prev;

    always_comb begin
        region_nxt = region;
        if (sample <= LO_TH)
            region_nxt = R_LOW;
        else if (sample >= HI_TH)
            region_nxt = R_HIGH;
    end

    // Only LOW -> HIGH counts; leaving UNKNOWN straight into HIGH does not.
    assign crossing = (region == R_LOW) && (region_nxt == R_HIGH);

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign win_min = (sample < wmin) ? sample : wmin;
    assign win_max = (sample > wmax) ? sample : wmax;

    // cnt excludes the crossing sample that opened the window, so the
    // number of samples seen since the window started is cnt_inc + 1.
    assign tmo_hit = ({1'b0, cnt_inc} + 17'd1) >= {1'b0, TIMEOUT};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            region       <= R_UNKNOWN;
            state        <= S_IDLE;
            cnt          <= '0;
            wmin         <= 8'hFF;
            wmax         <= 8'h00;
            have_prev    <= 1'b0;
            period       <= '0;
            min_val      <= '0;
            max_val      <= '0;
            lock         <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            if (clear) begin
                // Results are kept; only the tracking state restarts.
                region    <= R_UNKNOWN;
                state     <= S_IDLE;
                cnt       <= '0;
                lock      <= 1'b0;
                have_prev <= 1'b0;
            end else if (sample_valid) begin
                region <= region_nxt;
                if (state == S_IDLE) begin
                    if (crossing) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        wmin      <= 8'hFF;
                        wmax      <= 8'h00;
                        have_prev <= 1'b0;
                    end
                end else begin
                    // A crossing takes priority over the timeout threshold.
                    if (crossing) begin
                        period       <= cnt_inc;
                        min_val      <= win_min;
                        max_val      <= win_max;
                        result_valid <= 1'b1;
                        lock         <= have_prev && (cnt_inc == period);
                        have_prev    <= 1'b1;
                        cnt          <= '0;
                        wmin         <= 8'hFF;
                        wmax         <= 8'h00;
                    end else if (tmo_hit) begin
                        state     <= S_IDLE;
                        timeout   <= 1'b1;
                        lock      <= 1'b0;
                        have_prev <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt  <= cnt_inc;
                        wmin <= win_min;
                        wmax <= win_max;
                    end
                end
            end
        end
    end

endmodule

// File: doc/signal_analyzer.md
SIGNAL_ANALYZER -- requirements
Module: signal_analyzer

Interface
REQ-001 Parameter MID, default 127, is the midpoint code for crossing detection.
REQ-002 Parameter HYST, default 8, is the hysteresis half-width; legal range is MID-HYST >= 0 and MID+HYST <= 255.
REQ-003 Parameter TIMEOUT, default 16'hFFFF, is the maximum number of valid samples between crossings before the measurement is abandoned.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-006 Port sample_valid, input, 1 bit: the sample is accepted this cycle.
REQ-007 Port sample, input, 8 bits: unsigned waveform code (0..255), the function-generator output.
REQ-008 Port clear, input, 1 bit: synchronous restart of the measurement.
REQ-009 Port result_valid, output, 1 bit: one-cycle pulse when period, min_val and max_val update.
REQ-010 Port period, output, 16 bits: valid samples in the last complete cycle.
REQ-011 Port min_val, output, 8 bits: minimum sample in the last complete cycle.
REQ-012 Port max_val, output, 8 bits: maximum sample in the last complete cycle.
REQ-013 Port lock, output, 1 bit: the last two periods are equal.
REQ-014 Port timeout, output, 1 bit: one-cycle pulse when the measurement is abandoned.

Function
REQ-015 Region tracker states are UNKNOWN, LOW and HIGH; it updates only on accepted samples.
REQ-016 Region tracker transitions: any state -> LOW when sample <= MID-HYST; any state -> HIGH when sample >= MID+HYST; in-band samples hold the region.
REQ-017 A rising crossing is an accepted sample that moves the region LOW -> HIGH; UNKNOWN -> HIGH is not a crossing.
REQ-018 The measurement FSM has states IDLE and RUN; reset and clear enter IDLE.
REQ-019 IDLE -> RUN on a rising crossing, with no result; this starts the window with cnt=0, wmin=255 and wmax=0.
REQ-020 In RUN, each accepted sample sets cnt=cnt+1, wmin=min(wmin,sample) and wmax=max(wmax,sample); the crossing sample is included.
REQ-021 On a rising crossing in RUN: period=cnt+1, min_val and max_val take the window extremes including that sample, result_valid=1 the next cycle, and the window restarts empty.
REQ-022 Latency is exactly 1 clk from the accepting edge of the crossing sample to result_valid high; outputs then hold until the next result.
REQ-023 lock is updated with each result: 1 if the new period equals the previous reported period, else 0; the first result after IDLE sets lock=0.
REQ-024 In RUN, when cnt+1 reaches TIMEOUT without a crossing: go to IDLE, pulse timeout for 1 cycle, lock=0, no result; period, min_val and max_val hold; the region is retained.
REQ-025 cnt saturates and never wraps; TIMEOUT guarantees exit before cnt = 16'hFFFF.
REQ-026 With sample_valid=0, all state holds and cycles are not counted.
REQ-027 Simultaneous clear and crossing: clear wins; no result_valid, FSM in IDLE, region=UNKNOWN.
REQ-028 Simultaneous crossing and timeout threshold: the crossing wins and a result is reported.
REQ-029 The clear action is: region=UNKNOWN, FSM=IDLE, lock=0; period, min_val and max_val hold.

Reset
REQ-030 While rst=0: region=UNKNOWN, FSM=IDLE, cnt=0, period=0, min_val=0, max_val=0, lock=0, result_valid=0, timeout=0, asynchronously.
REQ-031 Reset release mid-waveform: the first rising crossing only arms RUN; the first result comes at the second crossing.

Verification
REQ-032 Square wave of 8x255 then 8x0, repeated, with sample_valid=1 -> results period=16, min_val=0, max_val=255; lock=0 on the first result and 1 from the second.
REQ-033 Ramp 0..255 by 1, repeated -> crossing at code 135, period=256, min_val=0, max_val=255, lock=1 from the second result.
REQ-034 Samples alternating 120/134 after the region is LOW -> no crossing, no result_valid, and no timeout until TIMEOUT is reached.
REQ-035 TIMEOUT=64, one crossing, then constant 0 -> timeout pulse after the 63rd valid sample; lock=0; FSM in IDLE; outputs held.
REQ-036 Square wave with sample_valid low every other cycle -> period=16, not 32.
REQ-037 The following cases give the required response:
- rst=0 mid-RUN -> all outputs 0 immediately.
- clear on a crossing sample -> no result_valid.
- the next two crossings -> one result only.
